// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Sequencer states: wait for start, shift one bit per clock, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed for a counter that can hold 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder used as the serial arithmetic cell.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures operands on start, adds LSB first through one
// full-add cell, and presents sum/cout/overflow with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;
  logic [WIDTH-1:0] w_res_next;

  // Operand conditioning at capture: subtract is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub ? 1'b1 : cin;
`else
  assign w_b_load   = b;
  assign w_cin_load = cin;
`endif

  fa_cell u_fa (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_c     (r_carry),
    .o_sum   (w_s),
    .o_carry (w_c)
  );

  // Result fills from the top so the first (LSB) bit ends at position 0.
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and capture strobe.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Serial datapath: operand shifters, carry, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_cin_load;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_res   <= w_res_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        sum      <= w_res_next;
        cout     <= w_c;
        overflow <= r_carry ^ w_c;
      end
    end
  end

  // Registered status flags decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_state_next == RUN);
      done <= (w_state_next == DONE);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 64 against an
// arithmetic reference model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int W_OF [3] = '{8, 1, 64};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_a [3];
  logic [63:0] in_b [3];
  logic        in_start [3];
  logic        in_cin [3];
`ifdef SERIAL_ADDER_SUB_EN
  logic        in_sub [3];
`endif

  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [63:0] sum64;
  logic [63:0] o_sum [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        cout_w [3];
  logic        ovf_w [3];

  assign o_sum[0] = 64'(sum8);
  assign o_sum[1] = 64'(sum1);
  assign o_sum[2] = sum64;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(in_start[0]),
    .a(in_a[0][7:0]), .b(in_b[0][7:0]), .cin(in_cin[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(in_sub[0]),
`endif
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum8),
    .cout(cout_w[0]), .overflow(ovf_w[0])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(in_start[1]),
    .a(in_a[1][0:0]), .b(in_b[1][0:0]), .cin(in_cin[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(in_sub[1]),
`endif
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum1),
    .cout(cout_w[1]), .overflow(ovf_w[1])
  );

  serial_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(in_start[2]),
    .a(in_a[2]), .b(in_b[2]), .cin(in_cin[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(in_sub[2]),
`endif
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum64),
    .cout(cout_w[2]), .overflow(ovf_w[2])
  );

  int unsigned passes = 0;
  int unsigned checks = 0;
  logic [63:0] prev_sum [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the masked operands.
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sv,
                       output logic [63:0] es, output logic ec, output logic eo);
    logic [63:0] m, aa, bb;
    logic [64:0] full;
    logic sa, sb, sr;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa = av & m;
    bb = bv & m;
    if (sv) begin
      full = {1'b0, aa} - {1'b0, bb};
      es   = full[63:0] & m;
      ec   = (aa >= bb);
    end else begin
      full = {1'b0, aa} + {1'b0, bb} + 65'(ci);
      es   = full[63:0] & m;
      ec   = full[w];
    end
    sa = aa[w-1];
    sb = bb[w-1];
    sr = es[w-1];
    eo = sv ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endtask

  // One full operation on DUT d, checking latency, result, pulse and hold.
  task automatic run_op(input int d, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sv);
    logic [63:0] es;
    logic ec, eo;
    int lat;
    model(W_OF[d], av, bv, ci, sv, es, ec, eo);
    in_a[d] = av; in_b[d] = bv; in_cin[d] = ci; in_start[d] = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    in_sub[d] = sv;
`endif
    @(posedge clk); #1;
    in_start[d] = 1'b0;
    in_a[d] = {$urandom, $urandom};
    in_b[d] = {$urandom, $urandom};
    in_cin[d] = 1'($urandom);
    chk("busy_after_accept", 64'(busy_w[d]), 64'd1);
    chk("sum_hold_run", o_sum[d], prev_sum[d]);
    lat = 0;
    while (!done_w[d] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(W_OF[d]));
    chk("sum", o_sum[d], es);
    chk("cout", 64'(cout_w[d]), 64'(ec));
    chk("overflow", 64'(ovf_w[d]), 64'(eo));
    chk("busy_in_done", 64'(busy_w[d]), 64'd0);
    prev_sum[d] = es;
    @(posedge clk); #1;
    chk("done_single", 64'(done_w[d]), 64'd0);
    chk("busy_idle", 64'(busy_w[d]), 64'd0);
    chk("sum_hold_idle", o_sum[d], es);
  endtask

  initial begin
    int done_at [$];
    int k;
    for (int i = 0; i < 3; i++) begin
      in_a[i] = '0; in_b[i] = '0; in_cin[i] = 1'b0; in_start[i] = 1'b0;
      prev_sum[i] = '0;
`ifdef SERIAL_ADDER_SUB_EN
      in_sub[i] = 1'b0;
`endif
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_w[0]), 64'd0);
    chk("rst_done", 64'(done_w[0]), 64'd0);
    chk("rst_sum", o_sum[0], 64'd0);
    chk("rst_cout", 64'(cout_w[0]), 64'd0);
    chk("rst_ovf", 64'(ovf_w[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases at WIDTH 8.
    run_op(0, 64'hFF, 64'h01, 1'b0, 1'b0);
    chk("c038_sum", o_sum[0], 64'h00);
    chk("c038_cout", 64'(cout_w[0]), 64'd1);
    chk("c038_ovf", 64'(ovf_w[0]), 64'd0);
    run_op(0, 64'h7F, 64'h01, 1'b0, 1'b0);
    chk("c039a_sum", o_sum[0], 64'h80);
    chk("c039a_cout", 64'(cout_w[0]), 64'd0);
    chk("c039a_ovf", 64'(ovf_w[0]), 64'd1);
    run_op(0, 64'h80, 64'h80, 1'b0, 1'b0);
    chk("c039b_sum", o_sum[0], 64'h00);
    chk("c039b_cout", 64'(cout_w[0]), 64'd1);
    chk("c039b_ovf", 64'(ovf_w[0]), 64'd1);
    run_op(0, 64'h12, 64'h34, 1'b1, 1'b0);
    chk("cin_sum", o_sum[0], 64'h47);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(0, 64'h05, 64'h07, 1'b1, 1'b1);
    chk("sub_a_sum", o_sum[0], 64'hFE);
    chk("sub_a_cout", 64'(cout_w[0]), 64'd0);
    run_op(0, 64'h07, 64'h05, 1'b0, 1'b1);
    chk("sub_b_sum", o_sum[0], 64'h02);
    chk("sub_b_cout", 64'(cout_w[0]), 64'd1);
`endif

    // Start held high: one done every WIDTH+2 cycles.
    in_a[0] = 64'h03; in_b[0] = 64'h04; in_cin[0] = 1'b0; in_start[0] = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_w[0]) done_at.push_back(k);
    end
    in_start[0] = 1'b0;
    chk("held_count", 64'(done_at.size()), 64'd4);
    for (int i = 0; i < done_at.size(); i++)
      chk("held_time", 64'(done_at[i]), 64'(9 + 10 * i));
    chk("held_sum", o_sum[0], 64'h07);
    prev_sum[0] = 64'h07;

    // Start pulse during RUN is ignored.
    in_a[0] = 64'h10; in_b[0] = 64'h20; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1; in_start[0] = 1'b1;
    @(posedge clk); #1; in_start[0] = 1'b0;
    k = 0;
    while (!done_w[0] && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ign_done_seen", 64'(done_w[0]), 64'd1);
    chk("ign_sum", o_sum[0], 64'h30);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("ign_no_done", 64'(done_w[0]), 64'd0);
      chk("ign_no_busy", 64'(busy_w[0]), 64'd0);
    end
    prev_sum[0] = 64'h30;

    // Reset in the middle of RUN aborts with no done.
    in_a[0] = 64'h55; in_b[0] = 64'h22; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_done", 64'(done_w[0]), 64'd0);
    chk("abort_sum", o_sum[0], 64'd0);
    chk("abort_cout", 64'(cout_w[0]), 64'd0);
    chk("abort_ovf", 64'(ovf_w[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_w[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) prev_sum[i] = '0;
    run_op(0, 64'h55, 64'h22, 1'b0, 1'b0);
    chk("post_rst_sum", o_sum[0], 64'h77);

    // Random operations at the width extremes.
    for (int n = 0; n < 1000; n++)
      run_op(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             SUB_EN ? 1'($urandom) : 1'b0);
    for (int n = 0; n < 1000; n++)
      run_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             SUB_EN ? 1'($urandom) : 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
